mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of requester and bus ports.
REQ-002 Parameter: DATA_W, 32, data width; byte-select width is DATA_W/8.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 flush  in  1  pipeline flush from ctrl; kills instruction-side traffic.
REQ-006 inst_req  in  1  fetch read request, held until inst_valid.
REQ-007 inst_addr  in  ADDR_W  fetch address.
REQ-008 inst_rdata  out  DATA_W  fetched word, registered.
REQ-009 inst_valid  out  1  one-cycle completion pulse for fetch.
REQ-010 stallreq_from_if  out  1  fetch stall request to ctrl.
REQ-011 data_req / data_we / data_sel / data_addr / data_wdata  in  1/1/DATA_W/8/ADDR_W/DATA_W  load-store request, fields held until data_valid.
REQ-012 data_rdata  out  DATA_W  load result, registered; data_valid  out  1  one-cycle completion pulse.
REQ-013 stallreq_from_mem  out  1  memory-stage stall request to ctrl.
REQ-014 bus_req / bus_we / bus_sel / bus_addr / bus_wdata  out  1/1/DATA_W/8/ADDR_W/DATA_W  shared bus request, all registered.
REQ-015 bus_ack  in  1  bus completion strobe; bus_rdata  in  DATA_W  read data valid with bus_ack.

Function
REQ-016 FSM states SHALL be IDLE, BUS_I, BUS_D, DROP_I; exactly one bus transaction outstanding at any time.
REQ-017 A requester is eligible in IDLE only if its req=1 and its own valid pulse is 0 this cycle, preventing re-issue during the completion cycle.
REQ-018 Instruction requester is ineligible in any cycle with flush=1.
REQ-019 One eligible requester: grant it. Both eligible: grant the one not in last_grant (round-robin); last_grant updates on every grant.
REQ-020 On grant, next edge: bus_req=1, bus fields latched from the granted requester; inst grant drives bus_we=0, bus_sel=all ones; state becomes BUS_I or BUS_D.
REQ-021 bus_req and latched fields SHALL stay constant until the edge sampling bus_ack=1; then bus_req=0, state=IDLE.
REQ-022 BUS_D with bus_ack=1: data_rdata<=bus_rdata and data_valid=1 for exactly the following cycle; on writes data_rdata is still updated (don't-care content).
REQ-023 BUS_I with bus_ack=1 and flush=0: inst_rdata<=bus_rdata and inst_valid pulse the following cycle.
REQ-024 BUS_I with flush=1 and bus_ack=0: go to DROP_I; bus_req stays 1 until ack.
REQ-025 DROP_I with bus_ack=1, or BUS_I with flush=1 and bus_ack=1: go to IDLE, no inst_valid, inst_rdata unchanged.
REQ-026 inst_valid output SHALL be the registered pulse gated by ~flush (combinational gate).
REQ-027 flush SHALL NOT affect BUS_D or data-side outputs; stores in flight always complete.
REQ-028 stallreq_from_if = inst_req & ~inst_valid; stallreq_from_mem = data_req & ~data_valid (combinational).
REQ-029 bus_ack in IDLE SHALL be ignored; a grant is made in the same IDLE cycle (min 1 idle cycle between transactions).
REQ-030 Minimum latency: req at cycle 0 -> bus_req cycle 1 -> ack cycle 1 -> valid cycle 2.

Reset
REQ-031 rst=1 at an edge: state=IDLE, last_grant=inst (data wins first tie), bus_req=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0, inst_rdata=0, data_rdata=0, inst_valid=0, data_valid=0.
REQ-032 Reset mid-transaction abandons it; a later bus_ack in IDLE produces no valid pulse.
REQ-033 Stall outputs follow REQ-028 during reset (valid=0, so they equal the req inputs).

Verification
REQ-034 Single fetch: inst_req=1 addr 0x1c000000, bus_ack 3 cycles after bus_req, rdata 0x02800c0c -> bus_we=0, sel=4'hf, inst_valid one cycle with 0x02800c0c, stallreq_from_if low that cycle.
REQ-035 Simultaneous inst_req and data_req (store, sel 4'b0011, wdata 0x1234) after reset -> data granted first, bus_we=1; inst granted next; third tie goes to data.
REQ-036 Flush during BUS_I, ack two cycles later -> state DROP_I, no inst_valid, inst_rdata unchanged, next fetch issues after ack.
REQ-037 Flush during BUS_D load, ack rdata 0xdeadbeef -> data_valid pulse with 0xdeadbeef unaffected.
REQ-038 rst asserted while bus_req=1, ack arrives after reset -> all outputs zero, no valid pulse, no re-grant until req eligible.
REQ-039 req held through completion cycle -> no duplicate bus transaction during valid pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one shared bus.
// One transaction is outstanding at a time; data wins ties until the grants start alternating.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic [DATA_W-1:0]     inst_rdata,
  output logic                  inst_valid,
  output logic                  stallreq_from_if,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [DATA_W/8-1:0]   data_sel,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  data_valid,
  output logic                  stallreq_from_mem,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_W/8-1:0]   bus_sel,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int unsigned SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUS_I  = 2'd1,
    BUS_D  = 2'd2,
    DROP_I = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                last_data_q, last_data_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [SEL_W-1:0]    bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                inst_valid_q, inst_valid_d;
  logic                data_valid_q, data_valid_d;

  logic                inst_elig;
  logic                data_elig;
  logic                grant_inst;
  logic                grant_data;

  // A requester in its completion cycle must not be re-issued; flush blocks fetch.
  assign inst_elig  = inst_req & ~inst_valid_q & ~flush;
  assign data_elig  = data_req & ~data_valid_q;
  assign grant_data = data_elig & (~inst_elig | ~last_data_q);
  assign grant_inst = inst_elig & ~grant_data;

  always_comb begin
    state_d      = state_q;
    last_data_d  = last_data_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_sel_d    = bus_sel_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_valid_d = 1'b0;
    data_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // bus_ack is ignored here; a stray ack after reset must not complete anything.
        if (grant_data) begin
          state_d     = BUS_D;
          last_data_d = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = data_we;
          bus_sel_d   = data_sel;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
        end else if (grant_inst) begin
          state_d     = BUS_I;
          last_data_d = 1'b0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = '1;
          bus_addr_d  = inst_addr;
          bus_wdata_d = '0;
        end
      end
      BUS_I: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (!flush) begin
            inst_rdata_d = bus_rdata;
            inst_valid_d = 1'b1;
          end
        end else if (flush) begin
          state_d = DROP_I;
        end
      end
      BUS_D: begin
        if (bus_ack) begin
          state_d      = IDLE;
          bus_req_d    = 1'b0;
          data_rdata_d = bus_rdata;
          data_valid_d = 1'b1;
        end
      end
      DROP_I: begin
        // Killed fetch still owns the bus until the slave acknowledges it.
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_data_q  <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_sel_q    <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_data_q  <= last_data_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_sel_q    <= bus_sel_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_valid_q <= inst_valid_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bus_req           = bus_req_q;
  assign bus_we            = bus_we_q;
  assign bus_sel           = bus_sel_q;
  assign bus_addr          = bus_addr_q;
  assign bus_wdata         = bus_wdata_q;
  assign inst_rdata        = inst_rdata_q;
  assign data_rdata        = data_rdata_q;
  assign inst_valid        = inst_valid_q & ~flush;
  assign data_valid        = data_valid_q;
  assign stallreq_from_if  = inst_req & ~inst_valid;
  assign stallreq_from_mem = data_req & ~data_valid;

endmodule
